// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS-subset field records into 32-bit words and
// streams them, tagged with sequential byte addresses, through a 2-entry FIFO.
module instr_encoder #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [AWIDTH-1:0] start_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AWIDTH-1:0] out_addr,
   output logic [DWIDTH-1:0] out_instr,
   output logic              busy,
   output logic              done,
   output logic              err_illegal,
   output logic [15:0]       word_count
);
   localparam logic [5:0] OPCODE_RTYPE = 6'h00, OPCODE_ADDI = 6'h08, OPCODE_SLTI = 6'h0A;
   localparam logic [5:0] OPCODE_LW = 6'h23, OPCODE_SW = 6'h2B, OPCODE_BEQ = 6'h04;
   localparam logic [5:0] OPCODE_J = 6'h02, OPCODE_JAL = 6'h03;
   localparam logic [5:0] FUNCT_ADD = 6'h20, FUNCT_SUB = 6'h22, FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR = 6'h25, FUNCT_NOR = 6'h27, FUNCT_SLT = 6'h2A, FUNCT_JR = 6'h08;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, state_nx;
   logic [AWIDTH-1:0] addr, sk_addr;
   logic [DWIDTH-1:0] enc, sk_instr;
   logic [5:0]        opcode, funct;
   logic              sk_valid, go, accept, legal, push, pop;

   if (DWIDTH != 32) begin : g_dwidth_check
      $error("instr_encoder: DWIDTH must be 32");
   end

   assign go       = start && state == IDLE;
   assign in_ready = state == RUN && !sk_valid;
   assign accept   = in_valid && in_ready;
   assign legal    = in_op < 4'd14;
   assign push     = accept && legal;
   assign pop      = out_valid && out_ready;
   assign busy     = state != IDLE;
   assign done     = state == DRAIN && !out_valid;

   always_comb begin
      opcode = OPCODE_RTYPE;
      funct  = FUNCT_ADD;
      case (in_op)
         4'd1:    funct  = FUNCT_SUB;
         4'd2:    funct  = FUNCT_AND;
         4'd3:    funct  = FUNCT_OR;
         4'd4:    funct  = FUNCT_NOR;
         4'd5:    funct  = FUNCT_SLT;
         4'd6:    funct  = FUNCT_JR;
         4'd7:    opcode = OPCODE_ADDI;
         4'd8:    opcode = OPCODE_SLTI;
         4'd9:    opcode = OPCODE_LW;
         4'd10:   opcode = OPCODE_SW;
         4'd11:   opcode = OPCODE_BEQ;
         4'd12:   opcode = OPCODE_J;
         4'd13:   opcode = OPCODE_JAL;
         default: ;
      endcase
   end

   assign enc = in_op <= 4'd5  ? {OPCODE_RTYPE, in_rs, in_rt, in_rd, in_shamt, funct} :
                in_op == 4'd6  ? {OPCODE_RTYPE, in_rs, 15'd0, funct} :
                in_op >= 4'd12 ? {opcode, in_target} :
                                 {opcode, in_rs, in_rt, in_imm};

   always_comb begin
      state_nx = state;
      if (go)
         state_nx = RUN;
      else if (state == RUN && accept && in_last)
         state_nx = DRAIN;
      else if (done)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         addr        <= '0;
         word_count  <= '0;
         err_illegal <= 1'b0;
      end else begin
         state <= state_nx;
         if (go) begin
            addr        <= start_addr & ~AWIDTH'(3);
            word_count  <= '0;
            err_illegal <= 1'b0;
         end
         if (push) begin
            addr <= addr + AWIDTH'(4);
            if (word_count != 16'hFFFF)
               word_count <= word_count + 16'd1;
         end
         if (accept && !legal)
            err_illegal <= 1'b1;
      end
   end

   // Head registers drive the outputs directly; the skid entry only fills while the head stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_instr <= '0;
         sk_valid  <= 1'b0;
         sk_addr   <= '0;
         sk_instr  <= '0;
      end else if (pop || !out_valid) begin
         out_valid <= sk_valid || push;
         if (sk_valid || push) begin
            out_addr  <= sk_valid ? sk_addr : addr;
            out_instr <= sk_valid ? sk_instr : enc;
         end
         sk_valid <= sk_valid && push;
         if (push) begin
            sk_addr  <= addr;
            sk_instr <= enc;
         end
      end else if (push) begin
         sk_valid <= 1'b1;
         sk_addr  <= addr;
         sk_instr <= enc;
      end
   end
endmodule
